mdu_iter: RTL and testbench



---
 rtl/mdu_iter.sv | 170 +++++++++++++++++
 tb/tb_mdu_iter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: one bit per cycle with valid/ready handshakes on both sides.
// Optional MDU_EARLY_OUT_EN: zero-operand multiplies and zero-dividend divides skip the iteration phase.
module mdu_iter #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int HW = XLEN / 2;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

   state_t              state;
   logic [3:0]          op_r;
   logic [XLEN-1:0]     a_r, b_r, opd, spec_val;
   logic [2*XLEN-1:0]   prod;
   logic [CNT_W-1:0]    cnt;
   logic                neg_hi, neg_lo, spec;

   logic                is_mul, is_div, is_w, is_rem, rsv, sgn_a, sgn_b;
   logic                a_neg, b_neg, div0, ovf, early, special;
   logic [XLEN-1:0]     ae, be, amag, bmag, min_val, spec_nxt;
   logic [XLEN:0]       mul_sum, div_sh;
   logic [XLEN-1:0]     div_diff;
   logic                div_ge;
   logic [2*XLEN-1:0]   pfin;
   logic [XLEN-1:0]     qv, rv, fix_val;

   function automatic logic [XLEN-1:0] sxw(input logic [HW-1:0] v);
      return {{HW{v[HW-1]}}, v};
   endfunction

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);

   always_comb begin
      is_mul  = (op_r <= 4'd3) || (op_r == 4'd8);
      is_div  = ((op_r >= 4'd4) && (op_r <= 4'd7)) || ((op_r >= 4'd9) && (op_r <= 4'd12));
      is_w    = (op_r >= 4'd8) && (op_r <= 4'd12);
      is_rem  = op_r inside {4'd6, 4'd7, 4'd11, 4'd12};
      rsv     = (op_r >= 4'd13);
      sgn_a   = op_r inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11};
      sgn_b   = op_r inside {4'd1, 4'd4, 4'd6, 4'd9, 4'd11};
      ae      = is_w ? (sgn_a ? sxw(a_r[HW-1:0]) : {{HW{1'b0}}, a_r[HW-1:0]}) : a_r;
      be      = is_w ? (sgn_b ? sxw(b_r[HW-1:0]) : {{HW{1'b0}}, b_r[HW-1:0]}) : b_r;
      a_neg   = sgn_a & ae[XLEN-1];
      b_neg   = sgn_b & be[XLEN-1];
      amag    = a_neg ? -ae : ae;
      bmag    = b_neg ? -be : be;
      min_val = is_w ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div0    = is_div && (be == '0);
      ovf     = is_div && sgn_b && (be == '1) && (ae == min_val);
`ifdef MDU_EARLY_OUT_EN
      early   = (is_mul && ((ae == '0) || (be == '0))) || (is_div && (ae == '0) && !div0);
`else
      early   = 1'b0;
`endif
      special = rsv || div0 || ovf || early;
      spec_nxt = '0;
      if (div0)
         spec_nxt = is_rem ? (is_w ? sxw(a_r[HW-1:0]) : a_r) : '1;
      else if (ovf)
         spec_nxt = is_rem ? '0 : ae;
   end

   // Multiply: add multiplicand into the upper half, then shift the whole product right.
   // Divide: prod holds {remainder, quotient}; the quotient bit shifts in at the LSB.
   always_comb begin
      mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opd};
      div_sh   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      div_diff = div_sh[XLEN-1:0] - opd;
      div_ge   = (div_sh >= {1'b0, opd});
      pfin     = neg_hi ? -prod : prod;
      qv       = neg_hi ? -prod[XLEN-1:0] : prod[XLEN-1:0];
      rv       = neg_lo ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
      fix_val  = '0;
      if (spec)
         fix_val = spec_val;
      else begin
         case (op_r)
            4'd0:               fix_val = pfin[XLEN-1:0];
            4'd1, 4'd2, 4'd3:   fix_val = pfin[2*XLEN-1:XLEN];
            4'd4, 4'd5:         fix_val = qv;
            4'd6, 4'd7:         fix_val = rv;
            4'd8:               fix_val = sxw(prod[XLEN-1:HW]);
            4'd9, 4'd10:        fix_val = sxw(qv[HW-1:0]);
            4'd11, 4'd12:       fix_val = sxw(rv[HW-1:0]);
            default:            fix_val = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         op_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         opd       <= '0;
         prod      <= '0;
         neg_hi    <= 1'b0;
         neg_lo    <= 1'b0;
         spec      <= 1'b0;
         spec_val  <= '0;
      end else if (flush) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               op_r  <= op;
               a_r   <= a;
               b_r   <= b;
               state <= S_PREP;
            end
            S_PREP: begin
               neg_hi   <= a_neg ^ b_neg;
               neg_lo   <= a_neg;
               opd      <= is_mul ? amag : bmag;
               // W divides park the 32-bit dividend in the upper word so its MSB shifts out first.
               if (is_mul)
                  prod <= {{XLEN{1'b0}}, bmag};
               else if (is_w)
                  prod <= {{XLEN{1'b0}}, amag[HW-1:0], {HW{1'b0}}};
               else
                  prod <= {{XLEN{1'b0}}, amag};
               cnt      <= is_w ? CNT_W'(HW) : CNT_W'(XLEN);
               spec     <= special;
               spec_val <= spec_nxt;
               state    <= special ? S_FIX : S_CALC;
            end
            S_CALC: begin
               cnt <= cnt - CNT_W'(1);
               if (is_mul)
                  prod <= prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
               else
                  prod <= {(div_ge ? div_diff : div_sh[XLEN-1:0]), prod[XLEN-2:0], div_ge};
               if (cnt == CNT_W'(1))
                  state <= S_FIX;
            end
            S_FIX: begin
               result    <= fix_val;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, handshake/flush/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0]  op;
   logic [63:0] a, b, result;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] last_exp = '0;

`ifdef MDU_EARLY_OUT_EN
   localparam int EO = 1;
`else
   localparam int EO = 0;
`endif

   mdu_iter #(.XLEN(64), .CNT_W(7)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [127:0]       xs, xu, ys, yu, p;
      logic signed [63:0] sa, sb;
      logic signed [31:0] sw, tw, q32;
      logic [31:0]        uw, vw, u32;
      logic [63:0]        r;
      xs = {{64{x[63]}}, x}; xu = {64'b0, x};
      ys = {{64{y[63]}}, y}; yu = {64'b0, y};
      sa = x; sb = y; sw = x[31:0]; tw = y[31:0]; uw = x[31:0]; vw = y[31:0];
      r = '0;
      case (o)
         4'd0: r = x * y;
         4'd1: begin p = xs * ys; r = p[127:64]; end
         4'd2: begin p = xs * yu; r = p[127:64]; end
         4'd3: begin p = xu * yu; r = p[127:64]; end
         4'd4: if (y == 0) r = '1;
               else if (x == 64'h8000000000000000 && y == '1) r = x;
               else r = sa / sb;
         4'd5: r = (y == 0) ? '1 : x / y;
         4'd6: if (y == 0) r = x;
               else if (x == 64'h8000000000000000 && y == '1) r = '0;
               else r = sa % sb;
         4'd7: r = (y == 0) ? x : x % y;
         4'd8: begin u32 = uw * vw; r = sx(u32); end
         4'd9: if (tw == 0) r = '1;
               else if (uw == 32'h80000000 && vw == 32'hFFFFFFFF) r = sx(32'h80000000);
               else begin q32 = sw / tw; r = sx(q32); end
         4'd10: if (vw == 0) r = '1; else begin u32 = uw / vw; r = sx(u32); end
         4'd11: if (tw == 0) r = sx(uw);
                else if (uw == 32'h80000000 && vw == 32'hFFFFFFFF) r = '0;
                else begin q32 = sw % tw; r = sx(q32); end
         4'd12: if (vw == 0) r = sx(uw); else begin u32 = uw % vw; r = sx(u32); end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      bit          w, dv, ml;
      logic [63:0] xx, yy;
      w  = (o >= 8 && o <= 12);
      dv = (o >= 4 && o <= 7) || (o >= 9 && o <= 12);
      ml = (o <= 3) || (o == 8);
      xx = w ? {32'b0, x[31:0]} : x;
      yy = w ? {32'b0, y[31:0]} : y;
      if (o > 12) return 2;
      if (dv && yy == 0) return 2;
      if ((o == 4 || o == 6) && x == 64'h8000000000000000 && y == '1) return 2;
      if ((o == 9 || o == 11) && x[31:0] == 32'h80000000 && y[31:0] == 32'hFFFFFFFF) return 2;
      if (EO != 0 && ml && (xx == 0 || yy == 0)) return 2;
      if (EO != 0 && dv && xx == 0) return 2;
      return w ? 34 : 66;
   endfunction

   task automatic run_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] er, input int el, input string nm, input int hold);
      int lat;
      bit quiet, stable;
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 4'($urandom_range(0, 15));
      lat = 0; quiet = 1'b1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (in_ready || !busy) quiet = 1'b0;
      end
      chk({nm, " latency"}, 64'(lat), 64'(el));
      chk({nm, " result"}, result, er);
      chk({nm, " in_ready low while busy"}, {63'b0, quiet}, 64'd1);
      if (hold > 0) begin
         stable = 1'b1;
         repeat (hold) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || result !== er) stable = 1'b0;
         end
         chk({nm, " held under backpressure"}, {63'b0, stable}, 64'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, " idle after consume"}, {62'b0, in_ready, out_valid}, 64'b10);
      last_exp = er;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a, b, res;
      int          lat;
      string       nm;
   } vec_t;

   vec_t tv[$];

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; a = '0; b = '0;

      tv.push_back('{4'd0,  64'd7, -64'sd3, 64'hFFFFFFFFFFFFFFEB, 66, "MUL 7*-3"});
      tv.push_back('{4'd3,  '1, '1, 64'hFFFFFFFFFFFFFFFE, 66, "MULHU max"});
      tv.push_back('{4'd2,  '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, 66, "MULHSU -1*2"});
      tv.push_back('{4'd1,  64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 66, "MULH min*min"});
      tv.push_back('{4'd4,  -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFD, 66, "DIV -7/2"});
      tv.push_back('{4'd6,  -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFF, 66, "REM -7/2"});
      tv.push_back('{4'd9,  64'h80000000, '1, 64'hFFFFFFFF80000000, 2, "DIVW ovf"});
      tv.push_back('{4'd10, 64'd100, 64'd7, 64'd14, 34, "DIVUW 100/7"});
      tv.push_back('{4'd5,  64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 2, "DIVU by 0"});
      tv.push_back('{4'd7,  64'd5, 64'd0, 64'd5, 2, "REMU by 0"});
      tv.push_back('{4'd4,  64'h8000000000000000, '1, 64'h8000000000000000, 2, "DIV ovf"});
      tv.push_back('{4'd6,  64'h8000000000000000, '1, 64'd0, 2, "REM ovf"});
      tv.push_back('{4'd9,  64'd5, 64'hFFFFFFFF00000000, 64'hFFFFFFFFFFFFFFFF, 2, "DIVW by 0"});
      tv.push_back('{4'd12, 64'h1234567880000005, 64'd0, 64'hFFFFFFFF80000005, 2, "REMUW by 0"});
      tv.push_back('{4'd8,  64'h7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 34, "MULW"});
      tv.push_back('{4'd11, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 34, "REMW -7%2"});
      tv.push_back('{4'd13, 64'd5, 64'd5, 64'd0, 2, "reserved op"});
      tv.push_back('{4'd0,  64'd0, 64'd123, 64'd0, (EO != 0) ? 2 : 66, "MUL zero"});
      tv.push_back('{4'd4,  64'd0, 64'd5, 64'd0, (EO != 0) ? 2 : 66, "DIV zero dividend"});

      #12;
      chk("reset state", {60'b0, in_ready, busy, out_valid, 1'b0}, 64'b1000);
      chk("reset result", result, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < tv.size(); i++)
         run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].res, tv[i].lat, tv[i].nm, 0);

      run_op(4'd10, 64'd100, 64'd7, 64'd14, 34, "backpressure", 10);

      // Flush during CALC cycle 20 of a MUL.
      begin
         bit never;
         @(negedge clk);
         op = 4'd0; a = 64'd9; b = 64'd11; in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         repeat (20) @(posedge clk);
         #1;
         flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
         chk("flush to idle", {61'b0, in_ready, busy, out_valid}, 64'b100);
         chk("flush keeps result", result, last_exp);
         never = 1'b1;
         repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) never = 1'b0;
         end
         chk("flush no late result", {63'b0, never}, 64'd1);
      end

      for (int i = 0; i < 40; i++) begin
         logic [3:0]  o;
         logic [63:0] x, y;
         o = ($urandom_range(0, 15) == 0) ? 4'(13 + $urandom_range(0, 2)) : 4'($urandom_range(0, 12));
         x = {$urandom, $urandom};
         y = {$urandom, $urandom};
         case ($urandom_range(0, 6))
            0: y = '0;
            1: x = '0;
            2: y = y >> $urandom_range(0, 63);
            3: x = x >> $urandom_range(0, 63);
            default: ;
         endcase
         run_op(o, x, y, ref_res(o, x, y), ref_lat(o, x, y), $sformatf("rand op%0d", o), 0);
      end

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      op = 4'd4; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset mid-op", {61'b0, in_ready, busy, out_valid}, 64'b100);
      chk("async reset result", result, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op(4'd5, 64'd1000, 64'd3, 64'd333, 66, "after reset", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
